// File: rtl/tqvp_utf8_stream_decoder_pkg.sv
// Shared types and constants for the UTF-8 stream decoder peripheral:
// lead-byte classification, FIFO entry layout and register map.
package utf8_pkg;

    typedef enum logic [3:0] {
        ASCII, CONT, L2, L3, L3_E0, L3_ED, L4, L4_F0, L4_F4, BAD
    } lead_class_e;

    typedef enum logic {IDLE, NEED} dec_state_e;

    typedef struct packed {
        logic [20:0] cp;
        logic        err;
        logic [2:0]  len;
    } cp_entry_t;

    localparam logic [20:0] REPL_CHAR = 21'hFFFD;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_HEAD   = 4'd1;
    localparam logic [3:0] ADDR_CTRL   = 4'd2;
    localparam logic [3:0] ADDR_EOS    = 4'd3;
    localparam logic [3:0] ADDR_CP0    = 4'd4;
    localparam logic [3:0] ADDR_CP1    = 4'd5;
    localparam logic [3:0] ADDR_CP2    = 4'd6;
    localparam logic [3:0] ADDR_CP3    = 4'd7;

    localparam int ST_VALID = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_BUSY  = 5;
    localparam int ST_ERR   = 4;
    localparam int ST_OVF   = 3;

    // Well-formed lead bytes per the Unicode table; C0/C1 and F5-FF can never start a sequence.
    function automatic lead_class_e classify(input logic [7:0] b);
        if (b < 8'h80)       return ASCII;
        else if (b < 8'hC0)  return CONT;
        else if (b < 8'hC2)  return BAD;
        else if (b < 8'hE0)  return L2;
        else if (b == 8'hE0) return L3_E0;
        else if (b == 8'hED) return L3_ED;
        else if (b < 8'hF0)  return L3;
        else if (b == 8'hF0) return L4_F0;
        else if (b < 8'hF4)  return L4;
        else if (b == 8'hF4) return L4_F4;
        else                 return BAD;
    endfunction

endpackage

// File: rtl/tqvp_utf8_stream_decoder_cp_fifo.sv
// Code-point FIFO with two ordered write ports (port 0 lands first) and one pop.
module utf8_cp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push0,
    input  logic [W-1:0]               data0,
    input  logic                       push1,
    input  logic [W-1:0]               data1,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign pop_ok = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= data0;
        if (push1) mem[wr_ptr + AW'(push0)] <= data1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/tqvp_utf8_stream_decoder.sv
// TinyQV peripheral: validating byte-stream UTF-8 decoder with maximal-subpart
// U+FFFD substitution, feeding a small code-point FIFO read back over the register bus.
module tqvp_utf8_stream_decoder
    import utf8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    dec_state_e  state, state_nx;
    logic [1:0]  need, need_nx;
    logic [7:0]  lo, lo_nx, hi, hi_nx;
    logic [20:0] acc, acc_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        err_flag, err_nx, ovf_flag, ovf_nx, replace, replace_nx;

    logic        first_push, idle_push, reprocess, byte_ok;
    cp_entry_t   first_entry, idle_entry, d0, d1, head;
    logic        push0, push1, fifo_pop, fifo_flush, empty, full;
    logic [CW-1:0] count;
    logic [2:0]  cnt_sat;
    lead_class_e cls;
    logic        unused_ui;

    assign unused_ui = ^ui_in;
    assign uo_out    = 8'h00;

    // Two pushes per byte at most, so a byte is only taken while two slots are free.
    assign byte_ok = (int'(count) <= DEPTH - 2);
    assign push0   = first_push | idle_push;
    assign push1   = first_push & idle_push;
    assign d0      = first_push ? first_entry : idle_entry;
    assign d1      = idle_entry;
    assign cnt_sat = (int'(count) > 7) ? 3'd7 : count[2:0];

    utf8_cp_fifo #(.DEPTH(DEPTH), .W($bits(cp_entry_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push0 (push0),
        .data0 (d0),
        .push1 (push1),
        .data1 (d1),
        .pop   (fifo_pop),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_nx = state; need_nx = need; lo_nx = lo; hi_nx = hi;
        acc_nx = acc; cnt_nx = cnt;
        err_nx = err_flag; ovf_nx = ovf_flag; replace_nx = replace;
        first_push = 1'b0; first_entry = '0; idle_push = 1'b0; idle_entry = '0;
        reprocess = 1'b0; fifo_pop = 1'b0; fifo_flush = 1'b0;
        cls = classify(data_in);
        if (data_write) begin
            case (address)
                ADDR_STATUS: begin
                    if (!byte_ok) begin
                        ovf_nx = 1'b1;
                    end else if (state == IDLE) begin
                        reprocess = 1'b1;
                    end else if (data_in >= lo && data_in <= hi) begin
                        acc_nx  = {acc[14:0], data_in[5:0]};
                        cnt_nx  = cnt + 3'd1;
                        need_nx = need - 2'd1;
                        lo_nx   = 8'h80;
                        hi_nx   = 8'hBF;
                        if (need == 2'd1) begin
                            first_push  = 1'b1;
                            first_entry = {acc_nx, 1'b0, cnt_nx};
                            state_nx    = IDLE;
                        end
                    end else begin
                        // Maximal subpart: replace what was consumed, then restart on this byte.
                        err_nx      = 1'b1;
                        first_push  = replace;
                        first_entry = {REPL_CHAR, 1'b1, cnt};
                        state_nx    = IDLE;
                        need_nx     = 2'd0;
                        reprocess   = 1'b1;
                    end
                end
                ADDR_HEAD: fifo_pop = 1'b1;
                ADDR_CTRL: begin
                    replace_nx = data_in[2];
                    if (data_in[1]) begin
                        err_nx = 1'b0;
                        ovf_nx = 1'b0;
                    end
                    if (data_in[0]) begin
                        fifo_flush = 1'b1;
                        state_nx   = IDLE;
                        need_nx    = 2'd0;
                    end
                end
                ADDR_EOS: begin
                    if (state != IDLE) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                        need_nx  = 2'd0;
                        if (replace && full) begin
                            ovf_nx = 1'b1;
                        end else if (replace) begin
                            first_push  = 1'b1;
                            first_entry = {REPL_CHAR, 1'b1, cnt};
                        end
                    end
                end
                default: ;
            endcase
        end
        if (reprocess) begin
            case (cls)
                ASCII: begin
                    idle_push  = 1'b1;
                    idle_entry = {13'd0, data_in, 1'b0, 3'd1};
                end
                L2: begin
                    state_nx = NEED; need_nx = 2'd1; cnt_nx = 3'd1;
                    lo_nx = 8'h80; hi_nx = 8'hBF;
                    acc_nx = {16'd0, data_in[4:0]};
                end
                L3, L3_E0, L3_ED: begin
                    state_nx = NEED; need_nx = 2'd2; cnt_nx = 3'd1;
                    lo_nx = (cls == L3_E0) ? 8'hA0 : 8'h80;
                    hi_nx = (cls == L3_ED) ? 8'h9F : 8'hBF;
                    acc_nx = {17'd0, data_in[3:0]};
                end
                L4, L4_F0, L4_F4: begin
                    state_nx = NEED; need_nx = 2'd3; cnt_nx = 3'd1;
                    lo_nx = (cls == L4_F0) ? 8'h90 : 8'h80;
                    hi_nx = (cls == L4_F4) ? 8'h8F : 8'hBF;
                    acc_nx = {18'd0, data_in[2:0]};
                end
                default: begin
                    err_nx     = 1'b1;
                    idle_push  = replace;
                    idle_entry = {REPL_CHAR, 1'b1, 3'd1};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE; need <= 2'd0; lo <= 8'h80; hi <= 8'hBF;
            acc <= '0; cnt <= '0;
            err_flag <= 1'b0; ovf_flag <= 1'b0; replace <= 1'b1;
        end else begin
            state <= state_nx; need <= need_nx; lo <= lo_nx; hi <= hi_nx;
            acc <= acc_nx; cnt <= cnt_nx;
            err_flag <= err_nx; ovf_flag <= ovf_nx; replace <= replace_nx;
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_STATUS: begin
                data_out[ST_VALID] = !empty;
                data_out[ST_FULL]  = full;
                data_out[ST_BUSY]  = (state != IDLE);
                data_out[ST_ERR]   = err_flag;
                data_out[ST_OVF]   = ovf_flag;
                data_out[2:0]      = cnt_sat;
            end
            ADDR_HEAD: if (!empty) data_out = {4'b0, head.err, head.len};
            ADDR_CTRL: data_out[2] = replace;
            ADDR_EOS:  data_out = {6'b0, need};
            ADDR_CP0:  if (!empty) data_out = head.cp[7:0];
            ADDR_CP1:  if (!empty) data_out = head.cp[15:8];
            ADDR_CP2:  if (!empty) data_out = {3'b0, head.cp[20:16]};
            default:   data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_utf8_stream_decoder.sv
// Scoreboard bench for the UTF-8 stream decoder: expected FIFO entries are queued
// as bytes are written and compared as the head is read back and popped.
module tb_tqvp_utf8_stream_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'd0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [24:0] exp_q[$];

    tqvp_utf8_stream_decoder #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] ent(input logic [20:0] cp, input logic err, input logic [2:0] len);
        return {cp, err, len};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic do_reset();
        @(negedge clk);
        data_write = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Reads the head entry through the register map, then pops it.
    task automatic read_head(output logic v, output logic [24:0] e);
        logic [7:0] s, h, b0, b1, b2;
        rd(4'd0, s); rd(4'd1, h); rd(4'd4, b0); rd(4'd5, b1); rd(4'd6, b2);
        v = s[7];
        e = {b2[4:0], b1, b0, h[3:0]};
        wr(4'd1, 8'h00);
    endtask

    task automatic test_reset();
        logic [7:0] r;
        rd(4'd0, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset status: got %h, expected 00", r); end
        rd(4'd2, r); tests_run++;
        if (r !== 8'h04) begin tests_failed++; $display("[TB] FAIL reset control: got %h, expected 04", r); end
        rd(4'd3, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset need: got %h, expected 00", r); end
        rd(4'd1, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset head: got %h, expected 00", r); end
        rd(4'd4, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset cp0: got %h, expected 00", r); end
        tests_run++;
        if (uo_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset uo_out: got %h, expected 00", uo_out); end
    endtask

    task automatic test_three_byte();
        logic [7:0] r, exp_b[4];
        logic [24:0] got, e;
        logic v;
        exp_b = '{8'hAC, 8'h20, 8'h00, 8'h00};
        wr(4'd0, 8'hE2); wr(4'd0, 8'h82); wr(4'd0, 8'hAC);
        exp_q.push_back(ent(21'h020AC, 1'b0, 3'd3));
        rd(4'd0, r); tests_run++;
        if (r !== 8'h81) begin tests_failed++; $display("[TB] FAIL three_byte status: got %h, expected 81", r); end
        rd(4'd1, r); tests_run++;
        if (r !== 8'h03) begin tests_failed++; $display("[TB] FAIL three_byte head: got %h, expected 03", r); end
        for (int i = 0; i < 4; i++) begin
            rd(4'(4 + i), r); tests_run++;
            if (r !== exp_b[i]) begin tests_failed++; $display("[TB] FAIL three_byte cp byte %0d: got %h, expected %h", i, r, exp_b[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL three_byte entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
        rd(4'd0, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL three_byte drained status: got %h, expected 00", r); end
    endtask

    task automatic test_four_byte();
        logic [7:0] r, exp_b[4];
        logic [24:0] got, e;
        logic v;
        exp_b = '{8'h00, 8'hF6, 8'h01, 8'h00};
        wr(4'd0, 8'hF0); wr(4'd0, 8'h9F); wr(4'd0, 8'h98); wr(4'd0, 8'h80);
        exp_q.push_back(ent(21'h1F600, 1'b0, 3'd4));
        for (int i = 0; i < 4; i++) begin
            rd(4'(4 + i), r); tests_run++;
            if (r !== exp_b[i]) begin tests_failed++; $display("[TB] FAIL four_byte cp byte %0d: got %h, expected %h", i, r, exp_b[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL four_byte entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
    endtask

    task automatic test_error_then_ascii();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        wr(4'd0, 8'hE2); wr(4'd0, 8'h41);
        exp_q.push_back(ent(21'h0FFFD, 1'b1, 3'd1));
        exp_q.push_back(ent(21'h00041, 1'b0, 3'd1));
        rd(4'd0, r); tests_run++;
        if (r !== 8'h92) begin tests_failed++; $display("[TB] FAIL err_ascii status: got %h, expected 92", r); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL err_ascii entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
        rd(4'd0, r); tests_run++;
        if (r !== 8'h10) begin tests_failed++; $display("[TB] FAIL err_ascii drained status: got %h, expected 10", r); end
        wr(4'd2, 8'h06);
        rd(4'd0, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL err_ascii cleared status: got %h, expected 00", r); end
    endtask

    task automatic test_surrogate_overlong();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        wr(4'd0, 8'hED); wr(4'd0, 8'hA0); wr(4'd0, 8'hC0);
        repeat (3) exp_q.push_back(ent(21'h0FFFD, 1'b1, 3'd1));
        rd(4'd0, r); tests_run++;
        if (r !== 8'h93) begin tests_failed++; $display("[TB] FAIL surrogate status: got %h, expected 93", r); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL surrogate entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
        wr(4'd2, 8'h06);
    endtask

    task automatic test_overflow();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        for (int i = 0; i < 5; i++) begin
            wr(4'd0, 8'h41);
            if (i < 3) exp_q.push_back(ent(21'h00041, 1'b0, 3'd1));
        end
        rd(4'd0, r); tests_run++;
        if (r !== 8'h8B) begin tests_failed++; $display("[TB] FAIL overflow status: got %h, expected 8b", r); end
        wr(4'd2, 8'h02);
        rd(4'd0, r); tests_run++;
        if (r !== 8'h83) begin tests_failed++; $display("[TB] FAIL overflow cleared status: got %h, expected 83", r); end
        rd(4'd2, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL overflow control: got %h, expected 00", r); end
        wr(4'd2, 8'h04);
        rd(4'd2, r); tests_run++;
        if (r !== 8'h04) begin tests_failed++; $display("[TB] FAIL overflow control restore: got %h, expected 04", r); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL overflow entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
        rd(4'd0, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL overflow drained status: got %h, expected 00", r); end
    endtask

    task automatic test_end_of_stream();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        wr(4'd0, 8'hF0); wr(4'd0, 8'h90);
        rd(4'd3, r); tests_run++;
        if (r !== 8'h02) begin tests_failed++; $display("[TB] FAIL eos need: got %h, expected 02", r); end
        rd(4'd0, r); tests_run++;
        if (r !== 8'h20) begin tests_failed++; $display("[TB] FAIL eos busy status: got %h, expected 20", r); end
        wr(4'd3, 8'h00);
        exp_q.push_back(ent(21'h0FFFD, 1'b1, 3'd2));
        rd(4'd0, r); tests_run++;
        if (r !== 8'h91) begin tests_failed++; $display("[TB] FAIL eos status: got %h, expected 91", r); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL eos entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
        wr(4'd2, 8'h02);
        wr(4'd0, 8'hF0); wr(4'd0, 8'h90); wr(4'd3, 8'h00);
        rd(4'd0, r); tests_run++;
        if (r !== 8'h10) begin tests_failed++; $display("[TB] FAIL eos no-replace status: got %h, expected 10", r); end
        wr(4'd2, 8'h06);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        wr(4'd0, 8'hC3); wr(4'd0, 8'hA9); wr(4'd0, 8'h41);
        exp_q.push_back(ent(21'h000E9, 1'b0, 3'd2));
        exp_q.push_back(ent(21'h00041, 1'b0, 3'd1));
        rd(4'd0, r); tests_run++;
        if (r !== 8'h82) begin tests_failed++; $display("[TB] FAIL back_to_back status: got %h, expected 82", r); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL back_to_back entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
    endtask

    task automatic test_flush();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        wr(4'd0, 8'h41); wr(4'd0, 8'hE2);
        rd(4'd0, r); tests_run++;
        if (r !== 8'hA1) begin tests_failed++; $display("[TB] FAIL flush pre status: got %h, expected a1", r); end
        wr(4'd2, 8'h05);
        rd(4'd0, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL flush status: got %h, expected 00", r); end
        wr(4'd0, 8'h82);
        exp_q.push_back(ent(21'h0FFFD, 1'b1, 3'd1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL flush entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
        wr(4'd2, 8'h06);
    endtask

    task automatic test_reset_mid_sequence();
        logic [7:0] r;
        logic [24:0] got, e;
        logic v;
        wr(4'd2, 8'h02);
        wr(4'd0, 8'h41); wr(4'd0, 8'h41); wr(4'd0, 8'hE2);
        rd(4'd0, r); tests_run++;
        if (r !== 8'hA2) begin tests_failed++; $display("[TB] FAIL reset_mid pre status: got %h, expected a2", r); end
        do_reset();
        rd(4'd0, r); tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_mid status: got %h, expected 00", r); end
        rd(4'd2, r); tests_run++;
        if (r !== 8'h04) begin tests_failed++; $display("[TB] FAIL reset_mid control: got %h, expected 04", r); end
        wr(4'd0, 8'h82);
        exp_q.push_back(ent(21'h0FFFD, 1'b1, 3'd1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); read_head(v, got); tests_run++;
            if (v !== 1'b1 || got !== e) begin tests_failed++; $display("[TB] FAIL reset_mid entry: got valid=%b %h, expected valid=1 %h", v, got, e); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        do_reset();
        test_reset();
        test_three_byte();
        test_four_byte();
        test_error_then_ascii();
        test_surrogate_overlong();
        test_overflow();
        test_end_of_stream();
        test_back_to_back();
        test_flush();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
